uart_operand_rx: RTL and testbench

- Serial receive front end for the memory-mapped peripheral block.
- Deserialises 8N1 UART frames from the board RX pin and pairs consecutive bytes into operands a and b.
- Raises ready when a full pair is available; holds it until the peripheral acknowledges the read.
- Sits directly upstream of the peripheral's operand and status registers, and feeds them a, b and ready.

---
 rtl/uart_operand_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_operand_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_operand_rx.sv
// uart_operand_rx: 8N1 UART receiver that pairs consecutive bytes into
// operands a/b with a ready/ack handshake and sticky error flags.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-high
//   din       - asynchronous serial RX line, idle high
//   ack       - one-cycle pulse, current pair consumed
//   a, b      - first and second byte of the last completed pair
//   ready     - pair valid and not yet acknowledged
//   overrun   - sticky, a pair was overwritten before ack
//   frame_err - sticky, a stop bit was sampled low
module uart_operand_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       ack,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       ready,
    output logic       overrun,
    output logic       frame_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ds;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  shadow_q;
    logic        sel_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        ready_q;
    logic        ovr_q;
    logic        ferr_q;

    // Shift-register synchroniser; idles high so reset looks like a quiet line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
        end
    end

    assign ds = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            shadow_q <= '0;
            sel_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            // Ack clears ready; a pair completing this same cycle overrides below.
            if (ack && ready_q) begin
                ready_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (!ds) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end

                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!ds) begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {ds, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (ds) begin
                            state_q <= IDLE;
                            if (!sel_q) begin
                                shadow_q <= shift_q;
                                sel_q    <= 1'b1;
                            end else begin
                                a_q     <= shadow_q;
                                b_q     <= shift_q;
                                ready_q <= 1'b1;
                                sel_q   <= 1'b0;
                                if (ready_q && !ack) begin
                                    ovr_q <= 1'b1;
                                end
                            end
                        end else begin
                            // Bad stop bit: drop the byte and restart pairing.
                            ferr_q  <= 1'b1;
                            sel_q   <= 1'b0;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                BREAK: begin
                    if (ds) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign ready     = ready_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_operand_rx.sv
// tb_uart_operand_rx: directed plus random frames for uart_operand_rx,
// checked against a byte-level pairing model.
module tb_uart_operand_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    // din fall -> sync -> start detect -> half bit -> 8 data + stop bit
    localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       ack;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       overrun;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit       m_pend;
    bit [7:0] m_sh;
    bit [7:0] m_a;
    bit [7:0] m_b;
    bit       m_ready;
    bit       m_ovr;
    bit       m_ferr;

    uart_operand_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .ack      (ack),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a"}, a, m_a);
        chk({tag, ".b"}, b, m_b);
        chk({tag, ".ready"}, {7'd0, ready}, {7'd0, m_ready});
        chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
        chk({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, m_ferr});
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_sh    = 0;
        m_a     = 0;
        m_b     = 0;
        m_ready = 0;
        m_ovr   = 0;
        m_ferr  = 0;
    endtask

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_ready = 0;
    endtask

    // stop_lo = 0 sends a clean frame; otherwise the stop bit is held low
    // for stop_lo cycles. ack_hit pulses ack into the pair-completion edge.
    task automatic send_byte(input logic [7:0] d, input int stop_lo,
                             input bit ack_hit);
        int  n;
        int  bi;
        bit  completes;
        bit  chk_lat;
        n = (stop_lo == 0) ? 10 * CPB : 9 * CPB + stop_lo;
        completes = (stop_lo == 0) && m_pend;
        chk_lat = completes && !m_ready;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (chk_lat && c == LAT - 1)
                chk("latency_pre", {7'd0, ready}, 8'd0);
            if (chk_lat && c == LAT)
                chk("latency_post", {7'd0, ready}, 8'd1);
            if (ack_hit) ack = (c == LAT - 1);
            bi = c / CPB;
            if (bi == 0) din = 1'b0;
            else if (bi <= 8) din = d[bi-1];
            else din = (stop_lo == 0);
        end
        idle(8);
        if (stop_lo != 0) begin
            m_ferr = 1;
            m_pend = 0;
        end else if (!m_pend) begin
            m_pend = 1;
            m_sh   = d;
        end else begin
            if (m_ready && !ack_hit) m_ovr = 1;
            m_a     = m_sh;
            m_b     = d;
            m_ready = 1;
            m_pend  = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b1;
        ack   = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        idle(4);

        // Clean pair
        send_byte(8'h12, 0, 0);
        check_all("s1_first");
        send_byte(8'h34, 0, 0);
        check_all("s1_pair");

        // Ack, then ack with ready low
        do_ack();
        check_all("s2_ack");
        do_ack();
        check_all("s2_ack_idle");

        // Ack landing on the completion edge
        send_byte(8'h77, 0, 0);
        send_byte(8'h88, 0, 0);
        check_all("sim_prep");
        send_byte(8'h99, 0, 0);
        send_byte(8'hAA, 0, 1);
        check_all("sim_ack");
        do_ack();

        // Overrun
        send_byte(8'hA5, 0, 0);
        send_byte(8'h5A, 0, 0);
        check_all("s3_pair1");
        send_byte(8'hFF, 0, 0);
        send_byte(8'h00, 0, 0);
        check_all("s3_overrun");
        do_ack();

        // Start glitch
        din = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check_all("s4_glitch");

        // Framing error and pair resync
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 40, 0);
        check_all("s5_ferr");
        send_byte(8'h33, 0, 0);
        send_byte(8'h44, 0, 0);
        check_all("s5_pair");

        // Reset mid-frame
        send_byte(8'h5C, 0, 0);
        for (int c = 0; c < 5 * CPB; c++) begin
            @(negedge clk);
            din = (c < CPB) ? 1'b0 : c[0];
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        din = 1'b1;
        model_reset();
        check_all("s6_reset");
        idle(2 * CPB);
        send_byte(8'h01, 0, 0);
        send_byte(8'h02, 0, 0);
        check_all("s6_pair");

        // Random pairs with random ack
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) do_ack();
            send_byte(8'($urandom_range(0, 255)), 0, 0);
            send_byte(8'($urandom_range(0, 255)), 0, 0);
            check_all("rand_pair");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
